// File: rtl/wrr_credit_arbiter.sv
// wrr_credit_arbiter
//   Weighted / plain round-robin arbiter with a rotating priority pointer.
//   A winner holds the grant for a burst of credit cycles. The credit is
//   weight*QUANTUM in weighted mode (saturated to CNT_W bits) and 1 in plain
//   RR mode. When a burst ends, the pointer moves past the burst owner and
//   arbitration is re-run on the same edge, so back-to-back bursts have no
//   idle cycle between them.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   req          in   [REQUESTORS]           level-sensitive request vector
//   weights      in   [REQUESTORS*WEIGHT_W]  requestor i at [i*WEIGHT_W +: WEIGHT_W]
//   mode         in   0 = plain RR, 1 = weighted
//   grant        out  [REQUESTORS]           registered one-hot grant
//   grant_valid  out  |grant
//   grant_idx    out  index of the granted requestor, 0 when idle
//   burst_done   out  high in the last cycle of a burst that ran to completion
module wrr_credit_arbiter #(
    parameter int REQUESTORS = 4,
    parameter int WEIGHT_W   = 8,
    parameter int QUANTUM    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REQUESTORS-1:0]            req,
    input  logic [REQUESTORS*WEIGHT_W-1:0]   weights,
    input  logic                             mode,
    output logic [REQUESTORS-1:0]            grant,
    output logic                             grant_valid,
    output logic [$clog2(REQUESTORS)-1:0]    grant_idx,
    output logic                             burst_done
);

    localparam int IDX_W  = $clog2(REQUESTORS);
    localparam int PROD_W = WEIGHT_W + 32;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        credit_q, credit_d;
    logic [REQUESTORS-1:0]   grant_q, grant_d;

    logic [REQUESTORS-1:0]   elig;
    logic [IDX_W-1:0]        scan_base;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_found;
    logic                    cur_req;
    logic                    burst_end;

    function automatic logic [IDX_W-1:0] next_of(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(REQUESTORS - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    // Full-width product so a large weight can never silently wrap.
    function automatic logic [CNT_W-1:0] credit_for(input logic [WEIGHT_W-1:0] w,
                                                    input logic             weighted);
        logic [PROD_W-1:0] prod;
        if (!weighted)
            return CNT_W'(1);
        prod = PROD_W'(w) * PROD_W'(QUANTUM);
        if ((prod >> CNT_W) != '0)
            return '1;
        return prod[CNT_W-1:0];
    endfunction

    always_comb begin
        elig      = '0;
        win_found = 1'b0;
        win_idx   = '0;

        for (int i = 0; i < REQUESTORS; i++)
            elig[i] = req[i] & (~mode | (weights[i*WEIGHT_W +: WEIGHT_W] != '0));

        // At a burst end the scan starts just after the owner, which is the
        // pointer value being written on this same edge.
        scan_base = (state_q == GRANT) ? next_of(idx_q) : rr_ptr_q;

        for (int off = 0; off < REQUESTORS; off++) begin
            int cand;
            cand = (int'(scan_base) + off) % REQUESTORS;
            if (!win_found && elig[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign cur_req    = req[idx_q];
    assign burst_end  = (state_q == GRANT) && (!cur_req || credit_q <= CNT_W'(1));
    // A burst cut short by a dropped request is not reported as done.
    assign burst_done = (state_q == GRANT) && cur_req && (credit_q == CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        credit_d = credit_q;
        grant_d  = grant_q;

        if (state_q == GRANT && !burst_end) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (state_q == IDLE || burst_end) begin
            if (state_q == GRANT)
                rr_ptr_d = next_of(idx_q);
            if (win_found) begin
                state_d          = GRANT;
                idx_d            = win_idx;
                credit_d         = credit_for(weights[int'(win_idx)*WEIGHT_W +: WEIGHT_W], mode);
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
            end else begin
                state_d  = IDLE;
                idx_d    = '0;
                credit_d = '0;
                grant_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            credit_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
module tb_wrr_credit_arbiter;

    localparam int N   = 4;
    localparam int WW  = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*WW-1:0] weights;
    logic           mode;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [1:0]     grant_idx;
    logic           burst_done;

    int checks = 0;
    int errors = 0;

    wrr_credit_arbiter #(
        .REQUESTORS(N),
        .WEIGHT_W  (WW),
        .QUANTUM   (2),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .weights    (weights),
        .mode       (mode),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .burst_done (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic ed);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
        chk({tag, ".idx"},   32'(grant_idx), 32'(idx_of(eg)));
        chk({tag, ".done"},  32'(burst_done), 32'(ed));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] eg;
        logic         ed;

        reset   = 1'b0;
        req     = 4'b1111;
        mode    = 1'b0;
        weights = '0;

        // Test 1: reset holds everything low even with all requests active.
        repeat (3) tick();
        chk_out("t1_in_reset", 4'b0000, 1'b0);
        reset = 1'b1;
        chk_out("t1_released", 4'b0000, 1'b0);
        tick();
        chk_out("t1_first", 4'b0001, 1'b1);

        // Test 2: plain RR, one-cycle bursts rotating 0,1,2,3,0,...
        for (int c = 1; c < 8; c++) begin
            tick();
            eg = 4'b0001 << (c % 4);
            chk_out($sformatf("t2_c%0d", c), eg, 1'b1);
        end

        // Test 3: weighted, w3..w0 = 0,3,2,1 -> bursts of 2,4,6, idx3 skipped.
        do_reset();
        mode    = 1'b1;
        weights = {8'd0, 8'd3, 8'd2, 8'd1};
        req     = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c <= 2)       eg = 4'b0001;
            else if (c <= 6)  eg = 4'b0010;
            else if (c <= 12) eg = 4'b0100;
            else              eg = 4'b0001;
            ed = (c == 2) || (c == 6) || (c == 12) || (c == 14);
            chk_out($sformatf("t3_c%0d", c), eg, ed);
        end

        // Test 4: early drop after 3 of 8 cycles, then a fresh full burst.
        do_reset();
        mode    = 1'b1;
        weights = 32'h0000_0004;
        req     = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk_out($sformatf("t4_c%0d", c), 4'b0001, 1'b0);
        end
        req = 4'b0000;
        chk("t4_drop_done", 32'(burst_done), 32'd0);
        tick();
        chk_out("t4_after_drop", 4'b0000, 1'b0);
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk_out($sformatf("t4_re_c%0d", c), 4'b0001, c == 8);
        end

        // Test 5: lone requestor 3, weight 1 -> continuous grant, 2-cycle bursts.
        do_reset();
        mode    = 1'b1;
        weights = 32'h0100_0000;
        req     = 4'b1000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk_out($sformatf("t5_c%0d", c), 4'b1000, (c % 2) == 0);
        end

        // Test 6: 255*2 saturates to 15 with a 4-bit counter; then reset mid-burst.
        do_reset();
        mode    = 1'b1;
        weights = 32'h0000_00FF;
        req     = 4'b0001;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk_out($sformatf("t6_c%0d", c), 4'b0001, c == 15);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk_out($sformatf("t6_b2_c%0d", c), 4'b0001, 1'b0);
        end
        #2;
        reset = 1'b0;
        mode  = 1'b0;
        req   = 4'b1111;
        #1;
        chk_out("t6_async_rst", 4'b0000, 1'b0);
        repeat (2) tick();
        chk_out("t6_held_rst", 4'b0000, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("t6_restart", 4'b0001, 1'b1);
        tick();
        chk_out("t6_restart2", 4'b0010, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
